// File: rtl/wb_pkg.sv
// wb_pkg: types and constants shared by the WB write-port arbiter and its result buffer.
package wb_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    STEAL = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_result_buf.sv
// wb_result_buf: one-entry holding register for an LLU result waiting for the
// register-file write port, plus the counter of cycles it has been blocked.
module wb_result_buf
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  clear,
  input  logic                  cnt_inc,
  output logic                  vld,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CNT_W-1:0]      cnt
);

  // Entry register; load and clear are never asserted together (load only when empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      rd   <= load_rd;
      data <= load_data;
    end
  end

  // Blocked-cycle counter, restarted whenever the entry is loaded or retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || clear) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline WB
// stage and the long-latency unit. Pipeline writes win; a blocked LLU result is
// buffered and, after STARVE_LIMIT blocked cycles, forced through with a
// one-cycle pipeline stall.
// Optional macro WB_PORT_ARB_BYPASS_EN: write an LLU result straight through
// when the port is idle instead of buffering it first.
//
//   state | meaning
//   IDLE  | buffer empty, LLU results accepted
//   HOLD  | buffered result waiting for a free port cycle
//   STEAL | pipeline stalled, buffered result owns the port this cycle
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  input  logic                  llu_valid,
  input  logic [REG_ADDR_W-1:0] llu_rd,
  input  logic [DATA_WIDTH-1:0] llu_wdata,
  output logic                  llu_ready,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  buf_busy,
  output logic [REG_ADDR_W-1:0] buf_rd
);

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e            state_q, state_d;
  logic                  buf_vld;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [CNT_W-1:0]      cnt;
  logic                  pipe_hit;
  logic                  llu_fire;
  logic                  llu_nz;
  logic                  bypass;
  logic                  buf_load;
  logic                  buf_clear;
  logic                  cnt_inc;

  assign pipe_hit  = pipe_we & (pipe_rd != '0);
  // Gated by rst so the LLU never sees a handshake while the block is held in reset.
  assign llu_ready = ~buf_vld & ~rst;
  assign llu_fire  = llu_valid & llu_ready;
  assign llu_nz    = (llu_rd != '0);
  assign stall_req = (state_q == STEAL);
  assign buf_busy  = buf_vld;

`ifdef WB_PORT_ARB_BYPASS_EN
  assign bypass = (state_q == IDLE) & llu_fire & llu_nz & ~pipe_hit;
`else
  assign bypass = 1'b0;
`endif

  wb_result_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_rd   (llu_rd),
    .load_data (llu_wdata),
    .clear     (buf_clear),
    .cnt_inc   (cnt_inc),
    .vld       (buf_vld),
    .rd        (buf_rd),
    .data      (buf_data),
    .cnt       (cnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and buffer control; a younger pipeline write to the same rd kills the entry.
  always_comb begin
    state_d   = state_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (llu_fire && llu_nz && !bypass) begin
          buf_load = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!pipe_hit || (pipe_rd == buf_rd)) begin
          buf_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (cnt == CNT_LAST) begin
            state_d = STEAL;
          end
        end
      end
      STEAL: begin
        buf_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency write-port mux: steal, pipeline, buffer, bypass, in that priority.
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (rst) begin
      rf_we = 1'b0;
    end else if (state_q == STEAL) begin
      rf_we    = 1'b1;
      rf_rd    = buf_rd;
      rf_wdata = buf_data;
    end else if (pipe_hit) begin
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_wdata = pipe_wdata;
    end else if (buf_vld) begin
      rf_we    = 1'b1;
      rf_rd    = buf_rd;
      rf_wdata = buf_data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_rd    = llu_rd;
      rf_wdata = llu_wdata;
    end
  end

endmodule
